// File: rtl/bp_cfg_regfile_pkg.sv
// Shared types for the boot configuration register file: register map,
// cache/coherence mode encodings, status layout and config-select values.
package bp_cfg_regfile_pkg;

  localparam int cfg_sel_width_lp     = 7;
  localparam int release_gap_width_lp = 8;

  typedef enum logic [7:0] {
    REG_FREEZE      = 8'h00,
    REG_CFG_SEL     = 8'h01,
    REG_ICACHE_MODE = 8'h02,
    REG_DCACHE_MODE = 8'h03,
    REG_CCE_MODE    = 8'h04,
    REG_RELEASE     = 8'h05,
    REG_STATUS      = 8'h06
  } cfg_reg_addr_e;

  typedef enum logic [1:0] {
    ICACHE_NORMAL   = 2'd0,
    ICACHE_NONSPEC  = 2'd1,
    ICACHE_UNCACHED = 2'd2,
    ICACHE_RSVD     = 2'd3
  } icache_mode_e;

  typedef enum logic [1:0] {
    DCACHE_NORMAL   = 2'd0,
    DCACHE_NONSPEC  = 2'd1,
    DCACHE_UNCACHED = 2'd2,
    DCACHE_RSVD     = 2'd3
  } dcache_mode_e;

  typedef enum logic [1:0] {
    CCE_NORMAL   = 2'd0,
    CCE_UNCACHED = 2'd1,
    CCE_UCODE    = 2'd2,
    CCE_RSVD     = 2'd3
  } cce_mode_e;

  typedef struct packed {
    logic sticky_err;
    logic busy;
  } cfg_status_s;

  typedef enum logic [cfg_sel_width_lp-1:0] {
    CFG_SEL_DEFAULT = 7'd0,
    CFG_SEL_ALT     = 7'd1
  } cfg_sel_e;

endpackage

// File: rtl/bp_cfg_release_seq.sv
// Staggered core release: picks the lowest still-frozen core and spaces
// successive clears by a programmable gap.
module bp_cfg_release_seq
  import bp_cfg_regfile_pkg::*;
#(
  parameter int num_core_p  = 4,
  parameter int gap_width_p = release_gap_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   i_start,
  input  logic                   i_active,
  input  logic [gap_width_p-1:0] i_gap,
  input  logic [num_core_p-1:0]  i_frozen,
  output logic                   o_fire,
  output logic                   o_last,
  output logic [num_core_p-1:0]  o_clear
);

  logic [gap_width_p-1:0] r_gap;
  logic [gap_width_p-1:0] r_cnt;

  // Descending scan so the lowest frozen index is the one left selected;
  // unfrozen cores are never selected, so they cost no gap cycles.
  always_comb begin
    o_clear = '0;
    for (int i = num_core_p - 1; i >= 0; i--) begin
      if (i_frozen[i]) begin
        o_clear    = '0;
        o_clear[i] = 1'b1;
      end
    end
    o_fire = i_active && (r_cnt == '0) && (|i_frozen);
    o_last = ((i_frozen & ~o_clear) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_gap <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_gap <= i_gap;
      r_cnt <= '0;
    end else if (o_fire) begin
      r_cnt <= r_gap;
    end else if (i_active && (r_cnt != '0)) begin
      r_cnt <= r_cnt - gap_width_p'(1);
    end
  end

endmodule

// File: rtl/bp_cfg_regfile.sv
// Boot configuration register file: one-outstanding command/response port,
// per-core freeze mask with staggered release, and mode/config outputs.
module bp_cfg_regfile
  import bp_cfg_regfile_pkg::*;
#(
  parameter int num_core_p       = 4,
  parameter int lg_max_cfgs_p    = 7,
  parameter int cfg_addr_width_p = 8,
  parameter int cfg_data_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_w_i,
  input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
  input  logic [cfg_data_width_p-1:0] cmd_data_i,

  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,

  output logic [num_core_p-1:0]       freeze_o,
  output logic [lg_max_cfgs_p-1:0]    cfg_sel_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic [1:0]                  cce_mode_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {READY, RESP, RELEASE} state_e;

  state_e                      r_state;
  logic [num_core_p-1:0]       r_freeze;
  logic [lg_max_cfgs_p-1:0]    r_cfgSel;
  icache_mode_e                r_icacheMode;
  dcache_mode_e                r_dcacheMode;
  cce_mode_e                   r_cceMode;
  logic                        r_stickyErr;
  logic                        r_respV;
  logic                        r_respErr;
  logic [cfg_data_width_p-1:0] r_respData;

  logic                        w_accept;
  logic                        w_wrFreeze;
  logic                        w_wrCfgSel;
  logic                        w_wrIcache;
  logic                        w_wrDcache;
  logic                        w_wrCce;
  logic                        w_wrRelease;
  logic                        w_rdStatus;
  logic                        w_respErrNext;
  logic [cfg_data_width_p-1:0] w_respDataNext;
  cfg_status_s                 w_status;
  logic                        w_relFire;
  logic                        w_relLast;
  logic [num_core_p-1:0]       w_relClear;
  logic [num_core_p-1:0]       w_freezeAfterClear;
  logic                        w_unusedData;

  assign cmd_ready_o   = (r_state == READY) && reset_n_i;
  assign w_accept      = cmd_v_i && cmd_ready_o;
  assign busy_o        = (r_state == RELEASE);
  assign resp_v_o      = r_respV;
  assign resp_data_o   = r_respData;
  assign resp_err_o    = r_respErr;
  assign freeze_o      = r_freeze;
  assign cfg_sel_o     = r_cfgSel;
  assign icache_mode_o = r_icacheMode;
  assign dcache_mode_o = r_dcacheMode;
  assign cce_mode_o    = r_cceMode;
  assign w_unusedData  = ^cmd_data_i;

  assign w_status.sticky_err = r_stickyErr;
  assign w_status.busy       = busy_o;
  assign w_freezeAfterClear  = r_freeze & ~w_relClear;

  // Decode the presented command into write strobes plus the response it earns.
  always_comb begin
    w_wrFreeze     = 1'b0;
    w_wrCfgSel     = 1'b0;
    w_wrIcache     = 1'b0;
    w_wrDcache     = 1'b0;
    w_wrCce        = 1'b0;
    w_wrRelease    = 1'b0;
    w_rdStatus     = 1'b0;
    w_respErrNext  = 1'b0;
    w_respDataNext = '0;
    case (cmd_addr_i)
      cfg_addr_width_p'(REG_FREEZE): begin
        if (cmd_w_i) begin
          w_wrFreeze     = 1'b1;
          w_respDataNext = cfg_data_width_p'(cmd_data_i[num_core_p-1:0]);
        end else begin
          w_respDataNext = cfg_data_width_p'(r_freeze);
        end
      end
      cfg_addr_width_p'(REG_CFG_SEL): begin
        if (!cmd_w_i) begin
          w_respDataNext = cfg_data_width_p'(r_cfgSel);
        end else if (&r_freeze) begin
          w_wrCfgSel     = 1'b1;
          w_respDataNext = cfg_data_width_p'(cmd_data_i[lg_max_cfgs_p-1:0]);
        end else begin
          w_respErrNext  = 1'b1;
        end
      end
      cfg_addr_width_p'(REG_ICACHE_MODE): begin
        w_wrIcache     = cmd_w_i;
        w_respDataNext = cmd_w_i ? cfg_data_width_p'(cmd_data_i[1:0])
                                 : cfg_data_width_p'(r_icacheMode);
      end
      cfg_addr_width_p'(REG_DCACHE_MODE): begin
        w_wrDcache     = cmd_w_i;
        w_respDataNext = cmd_w_i ? cfg_data_width_p'(cmd_data_i[1:0])
                                 : cfg_data_width_p'(r_dcacheMode);
      end
      cfg_addr_width_p'(REG_CCE_MODE): begin
        w_wrCce        = cmd_w_i;
        w_respDataNext = cmd_w_i ? cfg_data_width_p'(cmd_data_i[1:0])
                                 : cfg_data_width_p'(r_cceMode);
      end
      cfg_addr_width_p'(REG_RELEASE): begin
        w_wrRelease = cmd_w_i;
      end
      cfg_addr_width_p'(REG_STATUS): begin
        if (cmd_w_i) begin
          w_respErrNext  = 1'b1;
        end else begin
          w_rdStatus     = 1'b1;
          w_respDataNext = cfg_data_width_p'(w_status);
        end
      end
      default: begin
        w_respErrNext = 1'b1;
      end
    endcase
  end

  bp_cfg_release_seq #(
    .num_core_p  (num_core_p),
    .gap_width_p (release_gap_width_lp)
  ) releaseSeq (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_start   (w_accept && w_wrRelease),
    .i_active  (r_state == RELEASE),
    .i_gap     (cmd_data_i[release_gap_width_lp-1:0]),
    .i_frozen  (r_freeze),
    .o_fire    (w_relFire),
    .o_last    (w_relLast),
    .o_clear   (w_relClear)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state      <= READY;
      r_freeze     <= '1;
      r_cfgSel     <= lg_max_cfgs_p'(CFG_SEL_DEFAULT);
      r_icacheMode <= ICACHE_NORMAL;
      r_dcacheMode <= DCACHE_NORMAL;
      r_cceMode    <= CCE_NORMAL;
      r_stickyErr  <= 1'b0;
      r_respV      <= 1'b0;
      r_respErr    <= 1'b0;
      r_respData   <= '0;
    end else begin
      case (r_state)
        READY: begin
          if (w_accept) begin
            if (w_wrFreeze) r_freeze     <= cmd_data_i[num_core_p-1:0];
            if (w_wrCfgSel) r_cfgSel     <= cmd_data_i[lg_max_cfgs_p-1:0];
            if (w_wrIcache) r_icacheMode <= icache_mode_e'(cmd_data_i[1:0]);
            if (w_wrDcache) r_dcacheMode <= dcache_mode_e'(cmd_data_i[1:0]);
            if (w_wrCce)    r_cceMode    <= cce_mode_e'(cmd_data_i[1:0]);
            // The status read has already captured the sticky bit it clears.
            if (w_respErrNext)   r_stickyErr <= 1'b1;
            else if (w_rdStatus) r_stickyErr <= 1'b0;
            if (w_wrRelease && (|r_freeze)) begin
              r_state <= RELEASE;
            end else begin
              r_state    <= RESP;
              r_respV    <= 1'b1;
              r_respData <= w_respDataNext;
              r_respErr  <= w_respErrNext;
            end
          end
        end
        RELEASE: begin
          if (w_relFire) begin
            r_freeze <= w_freezeAfterClear;
            if (w_relLast) begin
              r_state    <= RESP;
              r_respV    <= 1'b1;
              r_respData <= cfg_data_width_p'(w_freezeAfterClear);
              r_respErr  <= 1'b0;
            end
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            r_state <= READY;
            r_respV <= 1'b0;
          end
        end
        default: begin
          r_state <= READY;
        end
      endcase
    end
  end

endmodule
